// File: rtl/game_state_pkg.sv
// Shared frame geometry, frame type and scheduler state encoding
// for the game display path.
package game_state_pkg;

   localparam int ROWS = 10;
   localparam int COLS = 20;

   typedef struct packed {
      logic [ROWS-1:0][COLS-1:0] screen;
   } game_state_t;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_SHOWING = 2'd1,
      ST_PENDING = 2'd2
   } sched_state_t;

endpackage

// File: rtl/game_frame_scheduler_rise_detect.sv
// Registered rising-edge detector; a level already high when reset
// releases must drop low before any edge is reported.
module rise_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise
);

   logic prev_q;
   logic armed_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         prev_q <= din;
         if (!din)
            armed_q <= 1'b1;
      end
   end

   assign rise = din & ~prev_q & armed_q;

endmodule

// File: rtl/game_frame_scheduler.sv
// Double-buffered frame scheduler between the game producer and the
// display refresh, with drop and stale reporting.
module game_frame_scheduler
   import game_state_pkg::*;
#(
   parameter int unsigned STALE_FRAMES = 120
) (
   input  logic              HSOSC_clk,
   input  logic              reset_n,
   input  logic              GAME_new_frame_ready,
   input  game_state_t       GAME_next_frame,
   input  logic              DISP_frame_start,
   input  logic [3:0]        DISP_row_addr,
   output logic [COLS-1:0]   DISP_row_data,
   output logic              DISP_frame_valid,
   output logic              SCHED_swap,
   output logic              SCHED_frame_dropped,
   output logic              SCHED_stale
);

   localparam int unsigned CW = $clog2(STALE_FRAMES + 1);
   localparam logic [CW-1:0] CMAX = CW'(STALE_FRAMES);
   localparam logic [3:0] ROW_LIM = 4'(ROWS);

   sched_state_t state_q, state_d;
   game_state_t front_q, front_d;
   game_state_t back_q, back_d;
   logic valid_d;
   logic swap_d, drop_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [COLS-1:0] row_d;
   logic cap;

   rise_detect u_rise (
      .clk  (HSOSC_clk),
      .rst_n(reset_n),
      .din  (GAME_new_frame_ready),
      .rise (cap)
   );

   always_ff @(posedge HSOSC_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q             <= ST_EMPTY;
         front_q             <= '0;
         back_q              <= '0;
         DISP_frame_valid    <= 1'b0;
         SCHED_swap          <= 1'b0;
         SCHED_frame_dropped <= 1'b0;
         cnt_q               <= '0;
         DISP_row_data       <= '0;
      end else begin
         state_q             <= state_d;
         front_q             <= front_d;
         back_q              <= back_d;
         DISP_frame_valid    <= valid_d;
         SCHED_swap          <= swap_d;
         SCHED_frame_dropped <= drop_d;
         cnt_q               <= cnt_d;
         DISP_row_data       <= row_d;
      end
   end

   always_comb begin
      state_d = state_q;
      front_d = front_q;
      back_d  = back_q;
      valid_d = DISP_frame_valid;
      swap_d  = 1'b0;
      drop_d  = 1'b0;
      unique case (state_q)
         ST_EMPTY: begin
            if (cap) begin
               front_d = GAME_next_frame;
               valid_d = 1'b1;
               state_d = ST_SHOWING;
            end
         end
         ST_SHOWING: begin
            if (cap) begin
               back_d  = GAME_next_frame;
               state_d = ST_PENDING;
            end
         end
         ST_PENDING: begin
            // A coincident capture refills back right after the swap,
            // so nothing is lost and no drop is reported.
            if (DISP_frame_start) begin
               front_d = back_q;
               swap_d  = 1'b1;
               if (cap)
                  back_d = GAME_next_frame;
               else
                  state_d = ST_SHOWING;
            end else if (cap) begin
               back_d = GAME_next_frame;
               drop_d = 1'b1;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (cap)
         cnt_d = '0;
      else if (DISP_frame_start && state_q != ST_EMPTY && cnt_q != CMAX)
         cnt_d = cnt_q + 1'b1;
   end

   // Read from the next front so a swap is visible on the following cycle.
   always_comb begin
      row_d = '0;
      if (valid_d && DISP_row_addr < ROW_LIM)
         row_d = front_d.screen[DISP_row_addr];
   end

   assign SCHED_stale = (cnt_q == CMAX);

endmodule

// File: tb/tb_game_frame_scheduler.sv
// Bench for game_frame_scheduler: directed scenarios plus random traffic
// against a queue-based frame model.
module tb_game_frame_scheduler;
   import game_state_pkg::*;

   localparam int SF = 3;

   logic HSOSC_clk = 1'b0;
   logic reset_n = 1'b0;
   logic GAME_new_frame_ready = 1'b0;
   game_state_t GAME_next_frame = '0;
   logic DISP_frame_start = 1'b0;
   logic [3:0] DISP_row_addr = '0;
   logic [COLS-1:0] DISP_row_data;
   logic DISP_frame_valid;
   logic SCHED_swap;
   logic SCHED_frame_dropped;
   logic SCHED_stale;

   int checks = 0;
   int errors = 0;

   always #5 HSOSC_clk = ~HSOSC_clk;

   game_frame_scheduler #(.STALE_FRAMES(SF)) dut (
      .HSOSC_clk          (HSOSC_clk),
      .reset_n            (reset_n),
      .GAME_new_frame_ready(GAME_new_frame_ready),
      .GAME_next_frame    (GAME_next_frame),
      .DISP_frame_start   (DISP_frame_start),
      .DISP_row_addr      (DISP_row_addr),
      .DISP_row_data      (DISP_row_data),
      .DISP_frame_valid   (DISP_frame_valid),
      .SCHED_swap         (SCHED_swap),
      .SCHED_frame_dropped(SCHED_frame_dropped),
      .SCHED_stale        (SCHED_stale)
   );

   // Model: shown frame plus a queue of frames waiting for a refresh.
   game_state_t m_front;
   game_state_t m_q[$];
   bit m_valid, m_prev, m_seen_low;
   int m_cnt;
   bit e_swap, e_drop;
   logic [COLS-1:0] e_row;

   function automatic void model_reset();
      m_front = '0;
      m_q.delete();
      m_valid = 0;
      m_prev = 0;
      m_seen_low = 0;
      m_cnt = 0;
      e_swap = 0;
      e_drop = 0;
      e_row = '0;
   endfunction

   function automatic void model_step(bit rdy, game_state_t f, bit fs,
                                      logic [3:0] a);
      bit cap;
      bit was_valid;
      cap = rdy && !m_prev && m_seen_low;
      was_valid = m_valid;
      e_swap = 0;
      e_drop = 0;
      if (fs && m_q.size() > 0) begin
         m_front = m_q.pop_front();
         e_swap = 1;
      end
      if (cap) begin
         if (!m_valid) begin
            m_front = f;
            m_valid = 1;
         end else begin
            if (m_q.size() > 0) begin
               m_q.delete();
               e_drop = 1;
            end
            m_q.push_back(f);
         end
      end
      if (cap)
         m_cnt = 0;
      else if (fs && was_valid && m_cnt < SF)
         m_cnt++;
      m_prev = rdy;
      if (!rdy)
         m_seen_low = 1;
      e_row = (m_valid && int'(a) < ROWS) ? m_front.screen[a] : '0;
   endfunction

   function automatic game_state_t rand_frame();
      game_state_t g;
      for (int r = 0; r < ROWS; r++)
         g.screen[r] = COLS'($urandom());
      return g;
   endfunction

   task automatic run(bit rdy, game_state_t f, bit fs, logic [3:0] a);
      @(negedge HSOSC_clk);
      GAME_new_frame_ready = rdy;
      GAME_next_frame = f;
      DISP_frame_start = fs;
      DISP_row_addr = a;
      @(posedge HSOSC_clk);
      model_step(rdy, f, fs, a);
      #1;
   endtask

   task automatic do_reset(bit rdy);
      @(negedge HSOSC_clk);
      reset_n = 1'b0;
      GAME_new_frame_ready = rdy;
      DISP_frame_start = 1'b0;
      model_reset();
      @(negedge HSOSC_clk);
      reset_n = 1'b1;
   endtask

   task automatic pulse(game_state_t f);
      run(1, f, 0, 0);
      run(1, rand_frame(), 0, 0);
      run(0, rand_frame(), 0, 0);
   endtask

   task automatic test_reset();
      game_state_t a;
      a = rand_frame();
      @(negedge HSOSC_clk);
      reset_n = 1'b0;
      GAME_new_frame_ready = 1'b1;
      model_reset();
      #2;
      checks++;
      if ({DISP_frame_valid, SCHED_swap, SCHED_frame_dropped, SCHED_stale,
           DISP_row_data} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %b/%b/%b/%b/%h want all 0",
                  DISP_frame_valid, SCHED_swap, SCHED_frame_dropped,
                  SCHED_stale, DISP_row_data);
      end
      @(negedge HSOSC_clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         run(1, a, 0, 0);
         checks++;
         if (DISP_frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL held_ready_ignored got %b want 0", DISP_frame_valid);
         end
      end
      run(0, a, 0, 0);
      run(1, a, 0, 0);
      checks++;
      if (DISP_frame_valid !== 1'b1 || SCHED_swap !== 1'b0) begin
         errors++;
         $display("FAIL first_frame valid/swap got %b/%b want 1/0",
                  DISP_frame_valid, SCHED_swap);
      end
      checks++;
      if (DISP_row_data !== a.screen[0]) begin
         errors++;
         $display("FAIL first_frame_row0 got %h want %h",
                  DISP_row_data, a.screen[0]);
      end
   endtask

   task automatic test_swap();
      game_state_t a, b;
      a = rand_frame();
      b = rand_frame();
      do_reset(0);
      pulse(a);
      pulse(b);
      for (int r = 0; r < ROWS; r++) begin
         run(0, rand_frame(), 0, 4'(r));
         checks++;
         if (DISP_row_data !== a.screen[r] || SCHED_swap !== 1'b0) begin
            errors++;
            $display("FAIL pre_swap_row%0d got %h swap %b want %h swap 0",
                     r, DISP_row_data, SCHED_swap, a.screen[r]);
         end
      end
      run(0, rand_frame(), 1, 0);
      checks++;
      if (SCHED_swap !== 1'b1) begin
         errors++;
         $display("FAIL swap_pulse got %b want 1", SCHED_swap);
      end
      for (int r = 0; r < ROWS; r++) begin
         run(0, rand_frame(), 0, 4'(r));
         checks++;
         if (DISP_row_data !== b.screen[r] || SCHED_swap !== 1'b0) begin
            errors++;
            $display("FAIL post_swap_row%0d got %h swap %b want %h swap 0",
                     r, DISP_row_data, SCHED_swap, b.screen[r]);
         end
      end
   endtask

   task automatic test_drop();
      game_state_t a, b, c;
      a = rand_frame();
      b = rand_frame();
      c = rand_frame();
      do_reset(0);
      pulse(a);
      pulse(b);
      run(1, c, 0, 0);
      checks++;
      if (SCHED_frame_dropped !== 1'b1) begin
         errors++;
         $display("FAIL drop_pulse got %b want 1", SCHED_frame_dropped);
      end
      run(1, rand_frame(), 0, 0);
      checks++;
      if (SCHED_frame_dropped !== 1'b0) begin
         errors++;
         $display("FAIL drop_width got %b want 0", SCHED_frame_dropped);
      end
      run(0, rand_frame(), 1, 0);
      for (int r = 0; r < ROWS; r++) begin
         run(0, rand_frame(), 0, 4'(r));
         checks++;
         if (DISP_row_data !== c.screen[r]) begin
            errors++;
            $display("FAIL drop_front_row%0d got %h want %h",
                     r, DISP_row_data, c.screen[r]);
         end
      end
   endtask

   task automatic test_coincident();
      game_state_t a, b, c;
      a = rand_frame();
      b = rand_frame();
      c = rand_frame();
      do_reset(0);
      pulse(a);
      pulse(b);
      run(1, c, 1, 2);
      checks++;
      if ({SCHED_swap, SCHED_frame_dropped} !== 2'b10 ||
          DISP_row_data !== b.screen[2]) begin
         errors++;
         $display("FAIL coincident swap/drop/row got %b%b %h want 10 %h",
                  SCHED_swap, SCHED_frame_dropped, DISP_row_data, b.screen[2]);
      end
      run(1, rand_frame(), 0, 0);
      run(0, rand_frame(), 0, 0);
      run(0, rand_frame(), 1, 3);
      checks++;
      if (SCHED_swap !== 1'b1 || DISP_row_data !== c.screen[3]) begin
         errors++;
         $display("FAIL coincident_back got swap %b row %h want 1 %h",
                  SCHED_swap, DISP_row_data, c.screen[3]);
      end
   endtask

   task automatic test_stale();
      do_reset(0);
      pulse(rand_frame());
      for (int i = 1; i <= 4; i++) begin
         run(0, rand_frame(), 1, 0);
         checks++;
         if (SCHED_stale !== (i >= SF)) begin
            errors++;
            $display("FAIL stale_after_%0d got %b want %b",
                     i, SCHED_stale, (i >= SF));
         end
      end
      run(1, rand_frame(), 0, 0);
      checks++;
      if (SCHED_stale !== 1'b0) begin
         errors++;
         $display("FAIL stale_clear got %b want 0", SCHED_stale);
      end
   endtask

   task automatic test_addr_async();
      game_state_t a, c;
      a = rand_frame();
      c = rand_frame();
      do_reset(0);
      pulse(a);
      run(0, rand_frame(), 0, 12);
      checks++;
      if (DISP_row_data !== '0) begin
         errors++;
         $display("FAIL addr12 got %h want 00000", DISP_row_data);
      end
      run(0, rand_frame(), 0, 9);
      checks++;
      if (DISP_row_data !== a.screen[9]) begin
         errors++;
         $display("FAIL addr9 got %h want %h", DISP_row_data, a.screen[9]);
      end
      pulse(rand_frame());
      @(negedge HSOSC_clk);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (DISP_frame_valid !== 1'b0 || DISP_row_data !== '0) begin
         errors++;
         $display("FAIL async_reset got valid %b row %h want 0 0",
                  DISP_frame_valid, DISP_row_data);
      end
      @(negedge HSOSC_clk);
      reset_n = 1'b1;
      run(0, rand_frame(), 0, 0);
      run(1, c, 0, 0);
      run(0, rand_frame(), 1, 4);
      checks++;
      if (SCHED_swap !== 1'b0 || DISP_row_data !== c.screen[4]) begin
         errors++;
         $display("FAIL discard_on_reset got swap %b row %h want 0 %h",
                  SCHED_swap, DISP_row_data, c.screen[4]);
      end
   endtask

   task automatic test_random();
      bit rdy;
      rdy = 0;
      do_reset(0);
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(2) == 0)
            rdy = ~rdy;
         run(rdy, rand_frame(), ($urandom_range(3) == 0),
             4'($urandom_range(15)));
         checks++;
         if ({DISP_frame_valid, SCHED_swap, SCHED_frame_dropped, SCHED_stale,
              DISP_row_data} !==
             {m_valid, e_swap, e_drop, (m_cnt == SF), e_row}) begin
            errors++;
            $display("FAIL random_cyc%0d got %b%b%b%b %h want %b%b%b%b %h",
                     i, DISP_frame_valid, SCHED_swap, SCHED_frame_dropped,
                     SCHED_stale, DISP_row_data, m_valid, e_swap, e_drop,
                     (m_cnt == SF), e_row);
         end
      end
   endtask

   initial begin
      test_reset();
      test_swap();
      test_drop();
      test_coincident();
      test_stale();
      test_addr_async();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
